// File: rtl/lii_pkg.sv
// Shared widths, tag type and the saturating drop counter helper for the LII adapter.
package lii_pkg;

   localparam int LII_ID_W       = 8;
   localparam int LII_SEL_W      = 2;
   localparam int LII_PW_DEFAULT = 256;

   typedef logic [LII_ID_W-1:0] lii_id_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a full FIFO refuses a push even when it pops.
module lii_sync_fifo
   import lii_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_cnt == CW'(DEPTH));
   assign empty  = (r_cnt == '0);
   assign w_push = push & !full;
   assign w_pop  = pop & !empty;
   assign rdata  = r_mem[r_rptr];

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wdata;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/lii_stream_adapter.sv
// Steers inbound LII beats into per-stream FIFOs and merges kernel outputs onto one LII channel.
module lii_stream_adapter
   import lii_pkg::*;
#(
   parameter int      NIN      = 2,
   parameter int      NOUT     = 2,
   parameter int      IW       = 96,
   parameter int      OW       = 192,
   parameter int      PW       = LII_PW_DEFAULT,
   parameter int      DEPTH    = 4,
   parameter lii_id_t NODE_ID  = 8'h00,
   parameter lii_id_t DST_BASE = 8'h00
) (
   input  logic               aclk,
   input  logic               arst,
   input  logic [PW-1:0]      lii_in_tdata,
   input  logic               lii_in_tvalid,
   output logic               lii_in_tready,
   input  logic [7:0]         lii_in_src,
   input  logic [7:0]         lii_in_dst,
   output logic [PW-1:0]      lii_out_tdata,
   output logic               lii_out_tvalid,
   input  logic               lii_out_tready,
   output logic [7:0]         lii_out_src,
   output logic [7:0]         lii_out_dst,
   output logic [NIN*IW-1:0]  kin_tdata,
   output logic [NIN-1:0]     kin_tvalid,
   input  logic [NIN-1:0]     kin_tready,
   input  logic [NOUT*OW-1:0] kout_tdata,
   input  logic [NOUT-1:0]    kout_tvalid,
   output logic [NOUT-1:0]    kout_tready,
   output logic               ce,
   output logic [15:0]        drop_cnt
);

   localparam int RW = (NOUT > 1) ? $clog2(NOUT) : 1;

   logic [LII_SEL_W-1:0] w_sel;
   logic                 w_sel_ok;
   logic [NIN-1:0]       w_full;
   logic [NIN-1:0]       w_empty;
   logic [3:0]           w_full_x;
   logic [NIN-1:0]       w_push;
   logic                 w_in_rdy;
   logic                 w_drop;
   logic                 w_load;
   logic                 w_gnt_vld;
   logic [RW-1:0]        w_gnt_idx;
   logic                 w_unused_ok;

   logic                 r_ov;
   logic [PW-1:0]        r_od;
   logic [RW-1:0]        r_oi;
   logic [RW-1:0]        r_rr;
   logic [15:0]          r_drop_cnt;

   assign w_unused_ok = ^{lii_in_src, lii_in_dst[7:LII_SEL_W], lii_in_tdata};

   // Inbound steering: streams beyond NIN are always accepted and discarded.
   assign w_sel    = lii_in_dst[LII_SEL_W-1:0];
   assign w_sel_ok = ({1'b0, w_sel} < 3'(NIN));
   assign w_in_rdy = !arst & (w_sel_ok ? !w_full_x[w_sel] : 1'b1);
   assign w_drop   = lii_in_tvalid & w_in_rdy & !w_sel_ok;
   assign lii_in_tready = w_in_rdy;

   // Pad the full flags to the whole select range so any sel indexes safely.
   always_comb begin
      w_full_x = '0;
      w_push   = '0;
      for (int i = 0; i < NIN; i++) begin
         w_full_x[i] = w_full[i];
         w_push[i]   = lii_in_tvalid & w_in_rdy & w_sel_ok & (w_sel == LII_SEL_W'(i));
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NIN; gi++) begin : g_in
         lii_sync_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
            .clk   (aclk),
            .rst   (arst),
            .push  (w_push[gi]),
            .wdata (lii_in_tdata[IW-1:0]),
            .pop   (kin_tready[gi]),
            .rdata (kin_tdata[gi*IW +: IW]),
            .full  (w_full[gi]),
            .empty (w_empty[gi])
         );
         assign kin_tvalid[gi] = !w_empty[gi];
      end
   endgenerate

   // Drop counter saturates rather than wrapping.
   always_ff @(posedge aclk) begin
      if (arst)        r_drop_cnt <= '0;
      else if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
   end
   assign drop_cnt = r_drop_cnt;

   // Round-robin pick: scan downward so the requester nearest rr wins.
   always_comb begin
      int idx;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int k = NOUT - 1; k >= 0; k--) begin
         idx = (int'(r_rr) + k) % NOUT;
         if (kout_tvalid[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = RW'(idx);
         end
      end
   end

   assign w_load = !r_ov | lii_out_tready;

   // Only the granted stream sees ready, and only when the output register can take it.
   always_comb begin
      kout_tready = '0;
      if (!arst && w_gnt_vld && w_load) kout_tready[w_gnt_idx] = 1'b1;
   end

   // Output register: reload whenever empty or draining; go idle if nobody requests.
   always_ff @(posedge aclk) begin
      if (arst) begin
         r_ov <= 1'b0;
         r_od <= '0;
         r_oi <= '0;
         r_rr <= '0;
      end else if (w_load) begin
         if (w_gnt_vld) begin
            r_ov <= 1'b1;
            r_od <= PW'(kout_tdata[int'(w_gnt_idx)*OW +: OW]);
            r_oi <= w_gnt_idx;
            r_rr <= (int'(w_gnt_idx) + 1 == NOUT) ? '0 : RW'(int'(w_gnt_idx) + 1);
         end else begin
            r_ov <= 1'b0;
         end
      end
   end

   assign lii_out_tvalid = r_ov;
   assign lii_out_tdata  = r_od;
   assign lii_out_dst    = DST_BASE + 8'(r_oi);
   assign lii_out_src    = NODE_ID;
   assign ce             = !arst & w_load;

endmodule

// File: tb/tb_lii_stream_adapter.sv
// Directed bench for lii_stream_adapter: steering, backpressure, drops, arbitration, stall, reset.
module tb_lii_stream_adapter;

   localparam int NIN = 2, NOUT = 2, IW = 96, OW = 192, PW = 256, DEPTH = 4;

   logic              aclk = 1'b0;
   logic              arst;
   logic [PW-1:0]     lii_in_tdata;
   logic              lii_in_tvalid;
   logic              lii_in_tready;
   logic [7:0]        lii_in_src;
   logic [7:0]        lii_in_dst;
   logic [PW-1:0]     lii_out_tdata;
   logic              lii_out_tvalid;
   logic              lii_out_tready;
   logic [7:0]        lii_out_src;
   logic [7:0]        lii_out_dst;
   logic [NIN*IW-1:0] kin_tdata;
   logic [NIN-1:0]    kin_tvalid;
   logic [NIN-1:0]    kin_tready;
   logic [NOUT*OW-1:0] kout_tdata;
   logic [NOUT-1:0]   kout_tvalid;
   logic [NOUT-1:0]   kout_tready;
   logic              ce;
   logic [15:0]       drop_cnt;

   int checks = 0;
   int errors = 0;

   lii_stream_adapter #(
      .NIN(NIN), .NOUT(NOUT), .IW(IW), .OW(OW), .PW(PW), .DEPTH(DEPTH),
      .NODE_ID(8'h5A), .DST_BASE(8'h10)
   ) dut (
      .aclk(aclk), .arst(arst),
      .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid), .lii_in_tready(lii_in_tready),
      .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
      .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid), .lii_out_tready(lii_out_tready),
      .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
      .kin_tdata(kin_tdata), .kin_tvalid(kin_tvalid), .kin_tready(kin_tready),
      .kout_tdata(kout_tdata), .kout_tvalid(kout_tvalid), .kout_tready(kout_tready),
      .ce(ce), .drop_cnt(drop_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      arst = 1'b1;
      lii_in_tdata = '0; lii_in_tvalid = 1'b0; lii_in_src = 8'h77; lii_in_dst = 8'h00;
      lii_out_tready = 1'b1; kin_tready = '0; kout_tdata = '0; kout_tvalid = '0;
      tick(); tick();
      #1;
      chk("rst_in_tready", lii_in_tready, 0);
      chk("rst_ce", ce, 0);
      chk("rst_kout_tready", kout_tready, 0);
      chk("rst_out_tvalid", lii_out_tvalid, 0);
      chk("rst_out_tdata", lii_out_tdata, 0);
      chk("rst_out_dst", lii_out_dst, 8'h10);
      chk("rst_out_src", lii_out_src, 8'h5A);
      chk("rst_kin_tvalid", kin_tvalid, 0);
      chk("rst_drop_cnt", drop_cnt, 0);

      // First cycle out of reset
      arst = 1'b0; lii_out_tready = 1'b0;
      #1;
      chk("post_rst_ce", ce, 1);
      chk("post_rst_in_tready", lii_in_tready, 1);

      // Steering
      lii_in_dst = 8'h00; lii_in_tdata = 256'hA1; lii_in_tvalid = 1'b1;
      #1;
      chk("steer_kin_pre", kin_tvalid, 2'b00);
      tick();
      lii_in_dst = 8'h01; lii_in_tdata = 256'hB2;
      #1;
      chk("steer_kin_v0", kin_tvalid, 2'b01);
      chk("steer_kin_d0", kin_tdata[IW-1:0], 96'hA1);
      tick();
      lii_in_tvalid = 1'b0;
      #1;
      chk("steer_kin_v1", kin_tvalid, 2'b11);
      chk("steer_kin_d1", kin_tdata[IW +: IW], 96'hB2);
      kin_tready = 2'b11;
      tick();
      kin_tready = 2'b00;
      #1;
      chk("steer_drained", kin_tvalid, 2'b00);

      // Input backpressure: fill stream 0, fifth beat refused
      lii_in_dst = 8'h00; lii_in_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lii_in_tdata = PW'(8'h10 + i);
         #1;
         chk("bp_fill_ready", lii_in_tready, 1);
         tick();
      end
      lii_in_tdata = 256'h14;
      #1;
      chk("bp_full_ready", lii_in_tready, 0);
      tick();
      chk("bp_head_hold", kin_tdata[IW-1:0], 96'h10);
      kin_tready = 2'b01;
      #1;
      chk("bp_full_pop_ready", lii_in_tready, 0);
      chk("bp_head0", kin_tdata[IW-1:0], 96'h10);
      tick();
      chk("bp_ready_after_pop", lii_in_tready, 1);
      chk("bp_head1", kin_tdata[IW-1:0], 96'h11);
      tick();
      lii_in_tvalid = 1'b0;
      #1;
      chk("bp_head2", kin_tdata[IW-1:0], 96'h12);
      tick();
      chk("bp_head3", kin_tdata[IW-1:0], 96'h13);
      tick();
      chk("bp_head4_v", kin_tvalid, 2'b01);
      chk("bp_head4", kin_tdata[IW-1:0], 96'h14);
      tick();
      chk("bp_empty", kin_tvalid, 2'b00);
      kin_tready = 2'b00;

      // Drops to an absent stream
      lii_in_dst = 8'h03; lii_in_tdata = 256'hDEAD; lii_in_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("drop_ready", lii_in_tready, 1);
         tick();
      end
      lii_in_tvalid = 1'b0;
      #1;
      chk("drop_kin_tvalid", kin_tvalid, 2'b00);
      chk("drop_cnt", drop_cnt, 16'd3);

      // Round-robin with both outputs requesting
      kout_tdata = {192'hD1D1, 192'hC0C0};
      kout_tvalid = 2'b11; lii_out_tready = 1'b1;
      #1;
      chk("rr_first_grant", kout_tready, 2'b01);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_valid", lii_out_tvalid, 1);
         chk("rr_dst", lii_out_dst, (i % 2 == 0) ? 8'h10 : 8'h11);
         chk("rr_data", lii_out_tdata, (i % 2 == 0) ? 256'hC0C0 : 256'hD1D1);
         chk("rr_next_grant", kout_tready, (i % 2 == 0) ? 2'b10 : 2'b01);
      end

      // Output stall
      lii_out_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ce", ce, 0);
         chk("stall_kout_tready", kout_tready, 2'b00);
         chk("stall_dst", lii_out_dst, 8'h11);
         chk("stall_data", lii_out_tdata, 256'hD1D1);
         chk("stall_valid", lii_out_tvalid, 1);
         tick();
      end
      lii_out_tready = 1'b1;
      #1;
      chk("release_ce", ce, 1);
      chk("release_grant", kout_tready, 2'b01);
      tick();
      chk("release_dst", lii_out_dst, 8'h10);
      chk("release_data", lii_out_tdata, 256'hC0C0);

      // Reset mid-flight: ov held, FIFO partially filled, rr pointing at stream 1
      lii_out_tready = 1'b0; kout_tvalid = 2'b00;
      lii_in_dst = 8'h00; lii_in_tvalid = 1'b1; lii_in_tdata = 256'h55;
      tick();
      lii_in_tdata = 256'h56;
      tick();
      lii_in_tvalid = 1'b0;
      #1;
      chk("pre_rst_kin_v", kin_tvalid, 2'b01);
      chk("pre_rst_out_v", lii_out_tvalid, 1);
      arst = 1'b1;
      tick();
      arst = 1'b0;
      #1;
      chk("midrst_kin_v", kin_tvalid, 2'b00);
      chk("midrst_out_v", lii_out_tvalid, 0);
      chk("midrst_out_d", lii_out_tdata, 0);
      chk("midrst_drop", drop_cnt, 0);
      kout_tvalid = 2'b11; lii_out_tready = 1'b1;
      #1;
      chk("midrst_grant", kout_tready, 2'b01);
      tick();
      chk("midrst_dst", lii_out_dst, 8'h10);
      chk("midrst_data", lii_out_tdata, 256'hC0C0);
      kout_tvalid = 2'b00;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
